// File: rtl/pixel_ops_pkg.sv
// rtl/pixel_ops_pkg.sv - shared state encoding, operation selects and widths for the point-op frame path
package pixel_ops_pkg;

    localparam int PIX_W_DEFAULT  = 8;
    localparam int ADDR_W_DEFAULT = 17;

    localparam logic [1:0] SEL_BRIGHTEN = 2'b00;
    localparam logic [1:0] SEL_DARKEN   = 2'b01;
    localparam logic [1:0] SEL_BINARISE = 2'b10;
    localparam logic [1:0] SEL_INVERT   = 2'b11;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_RUN   = 2'd1,
        FS_DRAIN = 2'd2,
        FS_DONE  = 2'd3
    } frame_state_e;

endpackage

// File: rtl/pix_skid_buf.sv
// rtl/pix_skid_buf.sv - one-entry skid register holding a pixel and its address
module pix_skid_buf
    import pixel_ops_pkg::*;
#(
    parameter int PIX_W  = PIX_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_tvalid,
    input  logic [PIX_W-1:0]  in_tdata,
    input  logic [ADDR_W-1:0] in_taddr,
    output logic              in_tready,
    output logic              out_tvalid,
    output logic [PIX_W-1:0]  out_tdata,
    output logic [ADDR_W-1:0] out_taddr,
    input  logic              out_tready
);

    logic              full;
    logic [PIX_W-1:0]  data_q;
    logic [ADDR_W-1:0] addr_q;

    assign in_tready  = !full;
    assign out_tvalid = full;
    assign out_tdata  = data_q;
    assign out_taddr  = addr_q;

    // Occupancy: fill only when empty, empty when the consumer takes the entry.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            full <= 1'b0;
        end else if (!full) begin
            full <= in_tvalid;
        end else if (out_tready) begin
            full <= 1'b0;
        end
    end

    // Payload capture while the entry is free.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            addr_q <= '0;
        end else if (!full && in_tvalid) begin
            data_q <= in_tdata;
            addr_q <= in_taddr;
        end
    end

endmodule

// File: rtl/pixel_frame_ctrl.sv
// rtl/pixel_frame_ctrl.sv - frame sequencer streaming source pixels through the point-op datapath to the sink
module pixel_frame_ctrl
    import pixel_ops_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int PIX_W  = PIX_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] frame_len,
    input  logic [1:0]        cfg_select,
    input  logic [PIX_W-1:0]  cfg_value,
    input  logic [PIX_W-1:0]  cfg_threshold,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic [1:0]        op_select,
    output logic [PIX_W-1:0]  op_value,
    output logic [PIX_W-1:0]  op_threshold,
    output logic [PIX_W-1:0]  op_inbyte,
    input  logic [PIX_W-1:0]  op_outbyte,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    input  logic              stall,
    output logic [ADDR_W-1:0] pix_count
);

    localparam logic [1:0] ST_IDLE  = FS_IDLE;
    localparam logic [1:0] ST_RUN   = FS_RUN;
    localparam logic [1:0] ST_DRAIN = FS_DRAIN;
    localparam logic [1:0] ST_DONE  = FS_DONE;

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [ADDR_W-1:0] len_q;

    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;

    logic              vb;
    logic [PIX_W-1:0]  b_data;
    logic [ADDR_W-1:0] b_addr;

    logic              skid_valid;
    logic              skid_ready;
    logic [PIX_W-1:0]  skid_data;
    logic [ADDR_W-1:0] skid_addr;

    logic              accept;
    logic              b_ready;
    logic              last_read;
    logic              pipe_empty;

    assign accept     = (state == ST_IDLE) && start && !abort;
    assign b_ready    = !vb || !stall;

    // Reads are gated directly by stall and the skid so that one skid entry
    // is always enough to absorb the single read that is already in flight.
    assign rd_en      = (state == ST_RUN) && !stall && skid_ready;
    assign last_read  = rd_en && (rd_addr == (len_q - ONE));

    assign wr_en      = vb && !stall;
    assign wr_addr    = b_addr;
    assign wr_data    = op_outbyte;
    assign op_inbyte  = b_data;

    // Drain is finished once the write leaving stage B this cycle is the last pixel.
    assign pipe_empty = !a_valid && !skid_valid && (!vb || wr_en);

    // Next-state selection; abort overrides every state.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start) state_next = (frame_len == '0) ? ST_DONE : ST_RUN;
                ST_RUN:   if (last_read) state_next = ST_DRAIN;
                ST_DRAIN: if (pipe_empty) state_next = ST_DONE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != ST_IDLE);
            done  <= (state_next == ST_DONE);
        end
    end

    // Frame configuration captured only when a start is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q        <= '0;
            op_select    <= '0;
            op_value     <= '0;
            op_threshold <= '0;
        end else if (accept) begin
            len_q        <= frame_len;
            op_select    <= cfg_select;
            op_value     <= cfg_value;
            op_threshold <= cfg_threshold;
        end
    end

    // Read address walks the frame one issued read at a time.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            rd_addr <= '0;
        end else if (rd_en) begin
            rd_addr <= rd_addr + ONE;
        end
    end

    // Accepted-write counter; survives abort so software can see progress.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            pix_count <= '0;
        end else if (wr_en) begin
            pix_count <= pix_count + ONE;
        end
    end

    // Stage A: tracks the read in flight and the address it belongs to.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            a_valid <= 1'b0;
            a_addr  <= '0;
        end else begin
            a_valid <= rd_en;
            a_addr  <= rd_addr;
        end
    end

    // Stage B: skid entry has priority so older pixels always leave first.
    always_ff @(posedge clk) begin
        if (rst) begin
            vb     <= 1'b0;
            b_data <= '0;
            b_addr <= '0;
        end else if (abort) begin
            vb <= 1'b0;
        end else if (b_ready) begin
            if (skid_valid) begin
                vb     <= 1'b1;
                b_data <= skid_data;
                b_addr <= skid_addr;
            end else if (a_valid) begin
                vb     <= 1'b1;
                b_data <= rd_data;
                b_addr <= a_addr;
            end else begin
                vb <= 1'b0;
            end
        end
    end

    pix_skid_buf #(
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .flush      (abort),
        .in_tvalid  (a_valid && !b_ready),
        .in_tdata   (rd_data),
        .in_taddr   (a_addr),
        .in_tready  (skid_ready),
        .out_tvalid (skid_valid),
        .out_tdata  (skid_data),
        .out_taddr  (skid_addr),
        .out_tready (b_ready)
    );

endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// tb/tb_pixel_frame_ctrl.sv - directed self-checking bench for pixel_frame_ctrl
module tb_pixel_frame_ctrl;

    localparam int ADDR_W = 17;
    localparam int PIX_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              stall = 1'b0;
    logic [ADDR_W-1:0] frame_len = '0;
    logic [1:0]        cfg_select = '0;
    logic [PIX_W-1:0]  cfg_value = '0;
    logic [PIX_W-1:0]  cfg_threshold = '0;
    logic              busy, done, rd_en, wr_en;
    logic [ADDR_W-1:0] rd_addr, wr_addr, pix_count;
    logic [PIX_W-1:0]  rd_data = '0;
    logic [1:0]        op_select;
    logic [PIX_W-1:0]  op_value, op_threshold, op_inbyte, op_outbyte, wr_data;
    logic [8:0]        sum9;

    logic [7:0] src [0:15];
    int exp_d [0:15];

    int n_checks = 0;
    int n_fail = 0;

    int wr_a[$];
    int wr_d[$];
    int wr_c[$];
    int done_c[$];
    int rd_n, rd_stall_n, busy_n, thr_bad, busy_after_abort;
    bit skid_seen;

    always #5 clk = ~clk;

    pixel_frame_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .frame_len     (frame_len),
        .cfg_select    (cfg_select),
        .cfg_value     (cfg_value),
        .cfg_threshold (cfg_threshold),
        .busy          (busy),
        .done          (done),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .op_select     (op_select),
        .op_value      (op_value),
        .op_threshold  (op_threshold),
        .op_inbyte     (op_inbyte),
        .op_outbyte    (op_outbyte),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .stall         (stall),
        .pix_count     (pix_count)
    );

    // Point-op datapath sitting on the op_* ports.
    always_comb begin
        sum9 = {1'b0, op_inbyte} + {1'b0, op_value};
        case (op_select)
            2'b00:   op_outbyte = sum9[8] ? 8'hff : sum9[7:0];
            2'b01:   op_outbyte = (op_inbyte > op_value) ? (op_inbyte - op_value) : 8'h00;
            2'b10:   op_outbyte = (op_inbyte >= op_threshold) ? 8'hff : 8'h00;
            default: op_outbyte = ~op_inbyte;
        endcase
    end

    // Source memory with one-cycle read latency.
    always @(posedge clk) begin
        rd_data <= src[rd_addr[3:0]];
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_frame(input int len, input int sel, input int val, input int thr,
                             input int stall_lo, input int stall_hi, input int abort_at,
                             input int restart_at, input int ncyc);
        wr_a.delete();
        wr_d.delete();
        wr_c.delete();
        done_c.delete();
        rd_n = 0;
        rd_stall_n = 0;
        busy_n = 0;
        thr_bad = 0;
        busy_after_abort = -1;
        skid_seen = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start         = 1'b1;
                frame_len     = len[ADDR_W-1:0];
                cfg_select    = sel[1:0];
                cfg_value     = val[7:0];
                cfg_threshold = thr[7:0];
            end else begin
                start         = (k == restart_at);
                frame_len     = 17'd5;
                cfg_select    = ~sel[1:0];
                cfg_value     = val[7:0] ^ 8'h5a;
                cfg_threshold = thr[7:0] + 8'd150;
            end
            stall = (k >= stall_lo) && (k <= stall_hi);
            abort = (k == abort_at);
            #1;
            if (wr_en) begin
                wr_a.push_back(int'(wr_addr));
                wr_d.push_back(int'(wr_data));
                wr_c.push_back(k);
            end
            if (rd_en) begin
                rd_n++;
                if (stall) rd_stall_n++;
            end
            if (done) done_c.push_back(k);
            if (busy) begin
                busy_n++;
                if (int'(op_threshold) != (thr & 255)) thr_bad++;
            end
            if (dut.u_skid.out_tvalid) skid_seen = 1'b1;
            if (k == abort_at + 1) busy_after_abort = int'(busy);
        end
        start = 1'b0;
        stall = 1'b0;
        abort = 1'b0;
    endtask

    task automatic check_stream(input string tag, input int n);
        chk({tag, "_wr_count"}, wr_a.size(), n);
        for (int i = 0; i < n && i < wr_a.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), wr_a[i], i);
            chk($sformatf("%s_data%0d", tag, i), wr_d[i], exp_d[i]);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) src[i] = 8'h00;

        // Reset held for two edges with start asserted and live config.
        rst = 1'b1;
        start = 1'b1;
        frame_len = 17'd4;
        cfg_select = 2'b11;
        cfg_value = 8'h33;
        cfg_threshold = 8'h44;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_op_select", int'(op_select), 0);
        chk("rst_op_value", int'(op_value), 0);
        chk("rst_op_threshold", int'(op_threshold), 0);
        chk("rst_op_inbyte", int'(op_inbyte), 0);
        chk("rst_pix_count", int'(pix_count), 0);
        chk("rst_state", int'(dut.state), 0);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_rd_en", int'(rd_en), 0);

        // Binarise, threshold 130.
        src[0] = 8'd0; src[1] = 8'd129; src[2] = 8'd130; src[3] = 8'd255;
        exp_d[0] = 0; exp_d[1] = 0; exp_d[2] = 255; exp_d[3] = 255;
        run_frame(4, 2, 0, 130, -1, -2, -10, -1, 10);
        check_stream("bin", 4);
        for (int i = 0; i < 4 && i < wr_c.size(); i++)
            chk($sformatf("bin_wr_cycle%0d", i), wr_c[i], 3 + i);
        chk("bin_done_count", done_c.size(), 1);
        if (done_c.size() > 0) chk("bin_done_cycle", done_c[0], 7);
        chk("bin_rd_count", rd_n, 4);
        chk("bin_busy_cycles", busy_n, 7);
        chk("bin_thr_stable", thr_bad, 0);
        chk("bin_pix_count", int'(pix_count), 4);
        chk("bin_idle_busy", int'(busy), 0);

        // Zero-length frame.
        run_frame(0, 0, 0, 0, -1, -2, -10, -1, 5);
        chk("zero_done_count", done_c.size(), 1);
        if (done_c.size() > 0) chk("zero_done_cycle", done_c[0], 1);
        chk("zero_busy_cycles", busy_n, 1);
        chk("zero_rd_count", rd_n, 0);
        chk("zero_wr_count", wr_a.size(), 0);
        chk("zero_pix_count", int'(pix_count), 0);

        // Brighten by 64 with stall in cycles 4..6.
        src[0] = 8'd0;   src[1] = 8'd100; src[2] = 8'd191; src[3] = 8'd192;
        src[4] = 8'd200; src[5] = 8'd250; src[6] = 8'd255; src[7] = 8'd63;
        exp_d[0] = 64;  exp_d[1] = 164; exp_d[2] = 255; exp_d[3] = 255;
        exp_d[4] = 255; exp_d[5] = 255; exp_d[6] = 255; exp_d[7] = 127;
        run_frame(8, 0, 64, 0, 4, 6, -10, -1, 22);
        check_stream("stall", 8);
        if (wr_c.size() > 1) begin
            chk("stall_first_wr_cycle", wr_c[0], 3);
            chk("stall_resume_cycle", wr_c[1], 7);
        end
        chk("stall_skid_used", int'(skid_seen), 1);
        chk("stall_rd_while_stalled", rd_stall_n, 0);
        chk("stall_rd_count", rd_n, 8);
        chk("stall_done_count", done_c.size(), 1);
        chk("stall_pix_count", int'(pix_count), 8);

        // Abort after five reads of a ten-pixel frame.
        for (int i = 0; i < 10; i++) src[i] = 8'(i * 7);
        run_frame(10, 1, 3, 0, -1, -2, 5, -1, 10);
        chk("abort_busy_next", busy_after_abort, 0);
        chk("abort_done_count", done_c.size(), 0);
        chk("abort_rd_count", rd_n, 5);
        chk("abort_wr_le3", int'(wr_a.size() <= 3), 1);
        chk("abort_pix_le5", int'(pix_count <= 17'd5), 1);
        chk("abort_state_idle", int'(dut.state), 0);

        // Fresh two-pixel invert frame after the abort.
        src[0] = 8'h12; src[1] = 8'hf0;
        exp_d[0] = 8'hed; exp_d[1] = 8'h0f;
        run_frame(2, 3, 0, 0, -1, -2, -10, -1, 8);
        check_stream("inv", 2);
        chk("inv_done_count", done_c.size(), 1);
        if (done_c.size() > 0) chk("inv_done_cycle", done_c[0], 5);
        chk("inv_pix_count", int'(pix_count), 2);

        // Start re-pulsed in RUN and threshold changed mid-frame.
        src[0] = 8'd99; src[1] = 8'd100; src[2] = 8'd200;
        exp_d[0] = 0; exp_d[1] = 255; exp_d[2] = 255;
        run_frame(3, 2, 0, 100, -1, -2, -10, 2, 12);
        check_stream("restart", 3);
        chk("restart_done_count", done_c.size(), 1);
        if (done_c.size() > 0) chk("restart_done_cycle", done_c[0], 6);
        chk("restart_thr_stable", thr_bad, 0);
        chk("restart_rd_count", rd_n, 3);
        chk("restart_pix_count", int'(pix_count), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
